// File: rtl/prog_loader.sv
// Boot-time program loader: streams a DEPTH-word image into RAM, verifies a
// trailing 8-bit checksum and releases the CPU reset only on a good image.
module prog_loader #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int DW        = 8,
  parameter int AUTOSTART = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] acc;
  logic [DW-1:0] sum_next;
  logic          xfer;

  assign in_ready = (state == S_LOAD) || (state == S_CHECK);
  assign busy     = in_ready;
  assign done     = (state == S_RUN);
  assign err      = (state == S_ERROR);
  assign xfer     = in_valid && in_ready;
  assign sum_next = acc + in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      ram_we    <= 1'b0;
      ram_adr   <= '0;
      ram_wdata <= '0;
      cpu_reset <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      cpu_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (AUTOSTART != 0 || start) state <= S_LOAD;
        end
        S_LOAD: begin
          if (xfer) begin
            ram_we    <= 1'b1;
            ram_adr   <= cnt;
            ram_wdata <= in_data;
            acc       <= sum_next;
            if (cnt == LAST_ADR) begin
              cnt   <= '0;
              state <= S_CHECK;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        S_CHECK: begin
          if (xfer) state <= (sum_next == '0) ? S_RUN : S_ERROR;
        end
        S_RUN, S_ERROR: begin
          // cpu_reset follows RUN one cycle late and drops on the restart edge
          if (start) begin
            state <= S_LOAD;
            cnt   <= '0;
            acc   <= '0;
          end else if (state == S_RUN) begin
            cpu_reset <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
